wbu_lsu: RTL and testbench

Writeback/load stage of the pipelined RV64 core: accepts one retiring instruction per handshake from the execute stage, performs the data-memory read for loads (request/grant, then read-valid), aligns and extends the returned data, and drives the register-file write port with a single-cycle registered write pulse. It is the sole producer of the regfile write port and of the per-instruction commit pulse.

---
 rtl/wbu_lsu_if.sv | 27 ++
 rtl/wbu_lsu.sv | 177 +++++++++++++++++
 tb/tb_wbu_lsu.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbu_lsu_if.sv
// Execute-stage handshake and data-memory read port of the writeback/load stage.
interface wbu_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_load;
    logic        in_wr_en;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [63:0] in_result;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    modport master (
        output in_valid, in_is_load, in_wr_en, in_rd, in_funct3, in_result,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  in_ready, mem_req, mem_addr
    );

    modport slave (
        input  in_valid, in_is_load, in_wr_en, in_rd, in_funct3, in_result,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output in_ready, mem_req, mem_addr
    );
endinterface

// File: rtl/wbu_lsu.sv
// RV64 writeback/load stage: retires ALU results directly, performs aligned
// doubleword reads for loads and drives the registered regfile write port.
module wbu_lsu #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    wbu_lsu_if.slave    bus,
    output logic        wr_en,
    output logic [4:0]  index_rd,
    output logic [63:0] data_rd,
    output logic        commit,
    output logic        load_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic        wr_en_q, wr_en_d;
    logic        commit_q, commit_d;
    logic        load_err_q, load_err_d;
    logic [4:0]  index_rd_q, index_rd_d;
    logic [63:0] data_rd_q, data_rd_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic        ld_wr_q, ld_wr_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [2:0]  ld_off_q, ld_off_d;
    logic        accept;
    logic        timeout;

    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
        case (f3)
            3'd1, 3'd5: misaligned = off[0];
            3'd2, 3'd6: misaligned = |off[1:0];
            3'd3:       misaligned = |off;
            3'd7:       misaligned = 1'b1;
            default:    misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] rdata,
                                                input logic [2:0]  f3,
                                                input logic [2:0]  off);
        logic [63:0]        sh;
        logic signed [7:0]  sb;
        logic signed [15:0] sh16;
        logic signed [31:0] sw;
        sh   = rdata >> {off, 3'b000};
        sb   = sh[7:0];
        sh16 = sh[15:0];
        sw   = sh[31:0];
        case (f3)
            3'd0:    load_extend = 64'(sb);
            3'd1:    load_extend = 64'(sh16);
            3'd2:    load_extend = 64'(sw);
            3'd4:    load_extend = {56'd0, sh[7:0]};
            3'd5:    load_extend = {48'd0, sh[15:0]};
            3'd6:    load_extend = {32'd0, sh[31:0]};
            default: load_extend = sh;
        endcase
    endfunction

    assign bus.in_ready = rstn && (state_q == IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    // Counter saturates, so a grant in the final REQ cycle still leaves WAIT bounded.
    assign timeout      = (cnt_q >= CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        wr_en_d    = 1'b0;
        commit_d   = 1'b0;
        load_err_d = 1'b0;
        index_rd_d = index_rd_q;
        data_rd_d  = data_rd_q;
        ld_rd_d    = ld_rd_q;
        ld_wr_d    = ld_wr_q;
        ld_f3_d    = ld_f3_q;
        ld_off_d   = ld_off_q;
        if (state_q != IDLE && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        case (state_q)
            IDLE: if (accept) begin
                if (!bus.in_is_load) begin
                    commit_d = 1'b1;
                    wr_en_d  = bus.in_wr_en && (bus.in_rd != 5'd0);
                    if (wr_en_d) begin
                        index_rd_d = bus.in_rd;
                        data_rd_d  = bus.in_result;
                    end
                end else begin
                    ld_rd_d  = bus.in_rd;
                    ld_wr_d  = bus.in_wr_en;
                    ld_f3_d  = bus.in_funct3;
                    ld_off_d = bus.in_result[2:0];
                    if (misaligned(bus.in_funct3, bus.in_result[2:0])) begin
                        commit_d   = 1'b1;
                        load_err_d = 1'b1;
                    end else begin
                        state_d    = REQ;
                        cnt_d      = 8'd0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {bus.in_result[63:3], 3'b000};
                    end
                end
            end
            REQ: if (bus.mem_gnt) begin
                state_d   = WAIT;
                mem_req_d = 1'b0;
            end else if (timeout) begin
                state_d    = IDLE;
                mem_req_d  = 1'b0;
                commit_d   = 1'b1;
                load_err_d = 1'b1;
            end
            WAIT: if (bus.mem_rvalid) begin
                state_d  = IDLE;
                commit_d = 1'b1;
                wr_en_d  = ld_wr_q && (ld_rd_q != 5'd0);
                if (wr_en_d) begin
                    index_rd_d = ld_rd_q;
                    data_rd_d  = load_extend(bus.mem_rdata, ld_f3_q, ld_off_q);
                end
            end else if (timeout) begin
                state_d    = IDLE;
                commit_d   = 1'b1;
                load_err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 64'd0;
            wr_en_q    <= 1'b0;
            commit_q   <= 1'b0;
            load_err_q <= 1'b0;
            index_rd_q <= 5'd0;
            data_rd_q  <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wr_en_q    <= wr_en_d;
            commit_q   <= commit_d;
            load_err_q <= load_err_d;
            index_rd_q <= index_rd_d;
            data_rd_q  <= data_rd_d;
        end
    end

    // Load context is only read after it has been captured on a load accept.
    always_ff @(posedge clk) begin
        ld_rd_q  <= ld_rd_d;
        ld_wr_q  <= ld_wr_d;
        ld_f3_q  <= ld_f3_d;
        ld_off_q <= ld_off_d;
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign wr_en        = wr_en_q;
    assign commit       = commit_q;
    assign load_err     = load_err_q;
    assign index_rd     = index_rd_q;
    assign data_rd      = data_rd_q;
endmodule

// File: tb/tb_wbu_lsu.sv
// Randomized bench for wbu_lsu against a transaction-level retirement model.
module tb_wbu_lsu;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en, commit, load_err;
    logic [4:0]  index_rd;
    logic [63:0] data_rd;

    always #5 clk = ~clk;

    wbu_lsu_if bus();

    wbu_lsu #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .wr_en(wr_en), .index_rd(index_rd), .data_rd(data_rd),
        .commit(commit), .load_err(load_err)
    );

    typedef struct packed {
        logic        wr;
        logic        err;
        logic [4:0]  idx;
        logic [63:0] data;
    } retire_t;

    retire_t     exp_ret[int];
    bit          busy[int];
    logic [63:0] req_at[int];
    int          cyc = 0;
    bit          rst_prev = 1'b1;
    bit          chk_en = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [4:0]  m_idx = 5'd0;
    logic [63:0] m_data = 64'd0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= !rstn;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] rd, input int f3, input int off);
        int          nbits;
        logic [63:0] v, mask;
        v = rd >> (8 * off);
        if (f3 % 4 == 3) return v;
        nbits = 8 << (f3 % 4);
        mask  = (64'd1 << nbits) - 64'd1;
        v     = v & mask;
        if (f3 < 4 && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit ref_bad(input int f3, input logic [63:0] a);
        if (f3 == 7) return 1'b1;
        return (a % (64'd1 << (f3 % 4))) != 64'd0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            retire_t r;
            bit      e_com, e_req, e_rdy;
            e_com = exp_ret.exists(cyc);
            if (e_com) r = exp_ret[cyc];
            else begin
                r.wr = 1'b0; r.err = 1'b0; r.idx = 5'd0; r.data = 64'd0;
            end
            e_req = req_at.exists(cyc);
            e_rdy = rstn && !busy.exists(cyc);
            if (rst_prev) begin
                e_com = 1'b0; r.wr = 1'b0; r.err = 1'b0; e_req = 1'b0;
                m_idx = 5'd0; m_data = 64'd0;
                check("rst_mem_addr", bus.mem_addr, 64'd0);
            end else if (r.wr) begin
                m_idx  = r.idx;
                m_data = r.data;
            end
            check("commit", 64'(commit), 64'(e_com));
            check("wr_en", 64'(wr_en), 64'(r.wr));
            check("load_err", 64'(load_err), 64'(r.err));
            check("index_rd", 64'(index_rd), 64'(m_idx));
            check("data_rd", data_rd, m_data);
            check("mem_req", 64'(bus.mem_req), 64'(e_req));
            if (e_req) check("mem_addr", bus.mem_addr, req_at[cyc]);
            check("in_ready", 64'(bus.in_ready), 64'(e_rdy));
        end
    end

    task automatic alu(input logic [4:0] rd, input bit we, input logic [63:0] res);
        retire_t r;
        bus.in_valid = 1'b1; bus.in_is_load = 1'b0; bus.in_wr_en = we;
        bus.in_rd = rd; bus.in_funct3 = 3'($urandom); bus.in_result = res;
        @(posedge clk); #1;
        r.wr = we && rd != 5'd0; r.err = 1'b0; r.idx = rd; r.data = res;
        exp_ret[cyc] = r;
        bus.in_valid = 1'b0; bus.in_is_load = 1'($urandom);
    endtask

    // dg/dr: edges after accept at which grant/rvalid are driven (>T means never).
    task automatic load(input int f3, input logic [63:0] addr, input logic [4:0] rd, input bit we,
                        input int dg, input int dr, input logic [63:0] rdata,
                        output int lat, output logic [63:0] addr_seen);
        retire_t r;
        int      a, fin, dl;
        bit      ok;
        bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_wr_en = we;
        bus.in_rd = rd; bus.in_funct3 = 3'(f3); bus.in_result = addr;
        @(posedge clk); #1;
        a = cyc;
        bus.in_valid = 1'b0;
        addr_seen = bus.mem_addr;
        r.idx = rd; r.wr = 1'b0; r.err = 1'b1; r.data = 64'd0;
        if (ref_bad(f3, addr)) begin
            exp_ret[a] = r;
            lat = 0;
            return;
        end
        if (dg > T) begin
            ok = 1'b0; fin = T;
        end else begin
            dl = (dg == T) ? T + 1 : T;
            if (dr <= dl) begin ok = 1'b1; fin = dr; end
            else begin ok = 1'b0; fin = dl; end
        end
        for (int k = 0; k < fin; k++) begin
            busy[a+k] = 1'b1;
            if (k < dg) req_at[a+k] = addr & ~64'h7;
        end
        if (ok) begin
            r.err = 1'b0;
            r.wr  = we && rd != 5'd0;
            r.data = ref_load(rdata, f3, int'(addr[2:0]));
        end
        exp_ret[a+fin] = r;
        for (int k = 1; k <= fin; k++) begin
            bus.mem_gnt    = (k == dg) || (k > dg && $urandom_range(0, 2) == 0);
            bus.mem_rvalid = (k == dr) || (k < dg && $urandom_range(0, 2) == 0);
            bus.mem_rdata  = (k == dr) ? rdata : {$urandom, $urandom};
            @(posedge clk); #1;
        end
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        lat = fin;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat, a, f3, dg, dr;
        logic [63:0] as, ad;
        bus.in_valid = 1'b0; bus.in_is_load = 1'b0; bus.in_wr_en = 1'b0;
        bus.in_rd = 5'd0; bus.in_funct3 = 3'd0; bus.in_result = 64'd0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_ready_low", 64'(bus.in_ready), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        alu(5'd5, 1'b1, 64'h1234);
        check("alu1_wr_en", 64'(wr_en), 64'd1);
        check("alu1_index", 64'(index_rd), 64'd5);
        check("alu1_data", data_rd, 64'h1234);
        alu(5'd0, 1'b1, 64'hFF);
        check("alu2_commit", 64'(commit), 64'd1);
        check("alu2_wr_en", 64'(wr_en), 64'd0);
        check("alu2_data_hold", data_rd, 64'h1234);

        load(0, 64'h1003, 5'd7, 1'b1, 3, 4, 64'h0000_0000_8000_0000, lat, as);
        check("lb_addr", as, 64'h1000);
        check("lb_data", data_rd, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_lat", 64'(lat), 64'd4);
        load(4, 64'h1003, 5'd8, 1'b1, 3, 4, 64'h0000_0000_8000_0000, lat, as);
        check("lbu_data", data_rd, 64'h80);
        load(6, 64'h1004, 5'd9, 1'b1, 1, 2, 64'h8765_4321_0000_0000, lat, as);
        check("lwu_data", data_rd, 64'h8765_4321);
        check("lwu_lat", 64'(lat), 64'd2);

        load(2, 64'h1002, 5'd3, 1'b1, 1, 2, 64'd0, lat, as);
        check("lw_mis_err", 64'(load_err), 64'd1);
        check("lw_mis_commit", 64'(commit), 64'd1);
        check("lw_mis_req", 64'(bus.mem_req), 64'd0);
        load(7, 64'h1000, 5'd3, 1'b1, 1, 2, 64'd0, lat, as);
        check("f3_7_err", 64'(load_err), 64'd1);
        check("f3_7_wr_en", 64'(wr_en), 64'd0);

        load(2, 64'h3000, 5'd3, 1'b1, 99, 99, 64'd0, lat, as);
        check("to_lat", 64'(lat), 64'd8);
        check("to_err", 64'(load_err), 64'd1);
        check("to_ready", 64'(bus.in_ready), 64'd1);
        load(3, 64'h3008, 5'd4, 1'b1, T, T + 1, 64'hDEAD_BEEF_0123_4567, lat, as);
        check("gnt_last_data", data_rd, 64'hDEAD_BEEF_0123_4567);
        load(1, 64'h300E, 5'd4, 1'b1, 2, T, 64'h8001_0000_0000_0000, lat, as);
        check("rv_last_data", data_rd, 64'hFFFF_FFFF_FFFF_8001);
        load(5, 64'h300E, 5'd4, 1'b1, 2, 99, 64'd0, lat, as);
        check("wait_to_err", 64'(load_err), 64'd1);

        bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_wr_en = 1'b1;
        bus.in_rd = 5'd4; bus.in_funct3 = 3'd3; bus.in_result = 64'h2000;
        @(posedge clk); #1;
        a = cyc;
        bus.in_valid = 1'b0;
        busy[a] = 1'b1; busy[a+1] = 1'b1; req_at[a] = 64'h2000;
        bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h5555;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        check("rst_wait_commit", 64'(commit), 64'd0);
        check("rst_wait_wr_en", 64'(wr_en), 64'd0);
        rstn = 1'b1;
        bus.mem_rvalid = 1'b1;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        check("post_rst_commit", 64'(commit), 64'd0);
        alu(5'd6, 1'b1, 64'hABCD);
        check("post_rst_alu", data_rd, 64'hABCD);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                alu(5'($urandom), $urandom_range(0, 3) != 0, {$urandom, $urandom});
            end else begin
                f3 = $urandom_range(0, 7);
                ad = {$urandom, $urandom};
                if ($urandom_range(0, 4) != 0) ad = ad & ~((64'd1 << (f3 % 4)) - 64'd1);
                dg = $urandom_range(1, 4);
                dr = dg + $urandom_range(1, 3);
                case ($urandom_range(0, 9))
                    0: begin dg = 99; dr = 99; end
                    1: dr = 99;
                    2: begin dg = T; dr = T + 1; end
                    3: begin dg = $urandom_range(1, T - 1); dr = T; end
                    default: ;
                endcase
                load(f3, ad, 5'($urandom), $urandom_range(0, 3) != 0, dg, dr,
                     {$urandom, $urandom}, lat, as);
            end
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk); #1;
            end
        end

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
